y_enhance_apply: RTL and testbench
==================================

Name: y_enhance_apply

Overview:
- Per-pixel contrast-stretch stage directly downstream of the luma statistics/rate block.
- Consumes the frame-level 8.8 fixed-point gain `rate` and black level `min_value` produced after each frame's EOP.
- Applies y' = sat255(((y - min) * rate) >> 8) to luma (bits 23:16) of an Avalon-ST-style 24-bit YCbCr stream. Chroma passes through untouched.
- Three-stage elastic pipeline with full valid/ready backpressure.

Parameters:
- PIPE_STAGES, 3, pipeline depth. Fixed; any other value is illegal and is rejected by an elaboration check.
- Y_MSB, 23, MSB of the luma byte in the data bus. The luma byte is Y_MSB:Y_MSB-7.

Ports:
- clk  input  1  single clock domain
- rst  input  1  synchronous, active-high reset
- video_in_data  input  24  pixel/header beat
- video_in_valid  input  1  beat present
- video_in_sop  input  1  first beat of packet
- video_in_eop  input  1  last beat of packet
- video_in_ready  output  1  stage can accept a beat this cycle
- video_out_data  output  24  processed beat
- video_out_valid  output  1  output beat present
- video_out_sop  output  1  first beat of packet
- video_out_eop  output  1  last beat of packet
- video_out_ready  input  1  downstream accepts
- rate  input  16  gain, 8.8 unsigned; 0x0100 = unity
- min_value  input  8  black level subtracted before gain
- enable  input  1  0 = pass all beats unmodified (latency unchanged)

Behaviour:
- Reset: one clk edge with rst=1 clears all stage valid bits and latched rate/min/type.
  - video_out_valid=0, video_out_sop=0, video_out_eop=0, video_out_data=0.
  - Latched rate resets to 0x0100, latched min to 0, latched is_video to 0.
- Handshake:
  - A beat transfers when valid & ready on the same edge.
  - Stage k advances when its successor is empty or advancing. adv3 = video_out_ready | ~s3_valid.
  - video_in_ready = ~s1_valid | adv1. It is combinational from video_out_ready through the chain and has no dependence on video_in_valid.
- Latency: exactly 3 cycles from accept to video_out_valid with video_out_ready held 1. Full throughput of 1 beat/clk.
- Output stability: while video_out_valid=1 and video_out_ready=0, all video_out_* hold stable. No beat is lost or duplicated.
- Frame coherence: on an accepted SOP beat, latch rate, min_value, enable, and is_video = (video_in_data[3:0]==0). These latched values apply to every beat of that packet. Changes to rate/min_value mid-packet have no effect until the next SOP.
- Header beat: the SOP beat always passes unmodified.
- Non-video packets: all beats of packets with a non-zero type (is_video=0) pass unmodified.
- Payload arithmetic (video packet, enable latched 1):
  - Stage 1: d = (y > min) ? y - min : 0, 8 bits unsigned.
  - Stage 2: p = d * rate, 24 bits unsigned.
  - Stage 3: r = p[23:8]; y' = (r > 255) ? 255 : r[7:0].
  - Bits 15:0 of the beat are delayed through the pipeline unchanged.
- Pass-through:
  - With latched rate 0x0100 and min 0, output equals input exactly.
  - With latched rate 0, every payload luma is 0.
- Packet without a trailing EOP followed by a new SOP: the new SOP re-latches parameters. No error flag is raised.
- Reset mid-packet: in-flight beats are discarded. The first accepted beat after reset is processed as pass-through until an SOP arrives, because is_video is 0.
- Simultaneous events: SOP and EOP on the same beat is a one-beat packet that latches parameters and passes unmodified.

Optional Feature:
- Macro: Y_ENHANCE_ROUND_EN.
- Defined: stage 3 computes r = (p + 24'h80) >> 8, rounding to nearest. Saturation is unchanged.
- Undefined: truncation, r = p >> 8.
- Latency and handshake are identical in both builds.

Test Plan:
- Identity: rate=0x0100, min=0, enable=1, 16-pixel video packet with luma 0..15 -> output bit-identical to input, first video_out_valid 3 cycles after first accept.
- Stretch: rate=0x0200, min=16, payload luma {80,10,255,16} -> {128,0,255,0}. Chroma and header unchanged.
- Coherence: rate changed 0x0200->0x0100 mid-packet -> all payload beats of that packet use 0x0200. The next packet uses 0x0100.
- Backpressure: hold video_out_ready=0 for 10 cycles during a 20-beat packet -> video_in_ready drops after 3 beats are buffered, outputs stay stable, all 20 beats are delivered in order with sop/eop intact.
- Control packet and enable: packet with header data[3:0]=0xF -> unmodified. enable=0 at SOP with rate=0x0300 -> packet unmodified.
- Rounding/reset: rate=0x0180, min=16, y=17 -> 1 without the macro, 2 with Y_ENHANCE_ROUND_EN. rst pulsed mid-packet -> video_out_valid=0 on the next cycle, and the following beats pass through until the next SOP.

Source files
------------

// File: rtl/y_enhance_apply.sv
// y_enhance_apply: 3-stage luma contrast stretch, y' = sat255(((y-min)*rate)>>8).
// Define Y_ENHANCE_ROUND_EN to round to nearest instead of truncating.
module y_enhance_apply #(
    parameter int PIPE_STAGES = 3,
    parameter int Y_MSB = 23
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] video_in_data,
    input  logic        video_in_valid,
    input  logic        video_in_sop,
    input  logic        video_in_eop,
    output logic        video_in_ready,
    output logic [23:0] video_out_data,
    output logic        video_out_valid,
    output logic        video_out_sop,
    output logic        video_out_eop,
    input  logic        video_out_ready,
    input  logic [15:0] rate,
    input  logic [7:0]  min_value,
    input  logic        enable
);

    generate
        if (PIPE_STAGES != 3) begin : g_bad_depth
            $error("y_enhance_apply: PIPE_STAGES must be 3");
        end
    endgenerate

    logic [15:0] rate_l;
    logic [7:0]  min_l;
    logic        en_l;
    logic        vid_l;

    logic        s1_v;
    logic [23:0] s1_data;
    logic        s1_sop;
    logic        s1_eop;
    logic        s1_mod;
    logic [7:0]  s1_d;
    logic [15:0] s1_rate;

    logic        s2_v;
    logic [23:0] s2_data;
    logic        s2_sop;
    logic        s2_eop;
    logic        s2_mod;
    logic [23:0] s2_p;

    logic rdy1;
    logic rdy2;
    logic rdy3;
    logic acc;

    // Each stage may load when it is empty or its contents move on.
    assign rdy3 = video_out_ready | ~video_out_valid;
    assign rdy2 = rdy3 | ~s2_v;
    assign rdy1 = rdy2 | ~s1_v;
    assign video_in_ready = rdy1;
    assign acc = video_in_valid & rdy1;

    logic [7:0] y_in;
    logic [7:0] d_in;
    logic       mod_in;

    assign y_in = video_in_data[Y_MSB -: 8];
    assign d_in = (y_in > min_l) ? (y_in - min_l) : 8'd0;
    // Header beats and beats of non-video packets stay untouched.
    assign mod_in = ~video_in_sop & vid_l & en_l;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v    <= 1'b0;
            s1_data <= '0;
            s1_sop  <= 1'b0;
            s1_eop  <= 1'b0;
            s1_mod  <= 1'b0;
            s1_d    <= '0;
            s1_rate <= '0;
            rate_l  <= 16'h0100;
            min_l   <= '0;
            en_l    <= 1'b0;
            vid_l   <= 1'b0;
        end else begin
            if (rdy1) begin
                s1_v <= video_in_valid;
            end
            if (acc) begin
                s1_data <= video_in_data;
                s1_sop  <= video_in_sop;
                s1_eop  <= video_in_eop;
                s1_mod  <= mod_in;
                s1_d    <= d_in;
                s1_rate <= rate_l;
                if (video_in_sop) begin
                    rate_l <= rate;
                    min_l  <= min_value;
                    en_l   <= enable;
                    vid_l  <= (video_in_data[3:0] == 4'd0);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_v    <= 1'b0;
            s2_data <= '0;
            s2_sop  <= 1'b0;
            s2_eop  <= 1'b0;
            s2_mod  <= 1'b0;
            s2_p    <= '0;
        end else begin
            if (rdy2) begin
                s2_v <= s1_v;
            end
            if (rdy2 & s1_v) begin
                s2_data <= s1_data;
                s2_sop  <= s1_sop;
                s2_eop  <= s1_eop;
                s2_mod  <= s1_mod;
                s2_p    <= 24'(s1_d) * 24'(s1_rate);
            end
        end
    end

    logic [23:0] p_rnd;
    logic [15:0] r;
    logic [7:0]  y_sat;
    logic [23:0] out_next;

`ifdef Y_ENHANCE_ROUND_EN
    assign p_rnd = s2_p + 24'h80;
`else
    assign p_rnd = s2_p;
`endif

    assign r = 16'(p_rnd >> 8);
    assign y_sat = (r > 16'd255) ? 8'hFF : r[7:0];

    always_comb begin
        out_next = s2_data;
        if (s2_mod) begin
            out_next[Y_MSB -: 8] = y_sat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            video_out_valid <= 1'b0;
            video_out_data  <= '0;
            video_out_sop   <= 1'b0;
            video_out_eop   <= 1'b0;
        end else begin
            if (rdy3) begin
                video_out_valid <= s2_v;
            end
            if (rdy3 & s2_v) begin
                video_out_data <= out_next;
                video_out_sop  <= s2_sop;
                video_out_eop  <= s2_eop;
            end
        end
    end

endmodule

// File: tb/tb_y_enhance_apply.sv
// Randomized + directed bench for y_enhance_apply with a packet-level model.
// The model tracks per-packet parameters and predicts every output beat.
module tb_y_enhance_apply;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] video_in_data = '0;
    logic        video_in_valid = 1'b0;
    logic        video_in_sop = 1'b0;
    logic        video_in_eop = 1'b0;
    logic        video_in_ready;
    logic [23:0] video_out_data;
    logic        video_out_valid;
    logic        video_out_sop;
    logic        video_out_eop;
    logic        video_out_ready = 1'b1;
    logic [15:0] rate = 16'h0100;
    logic [7:0]  min_value = '0;
    logic        enable = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rdy_mode = 1;

    logic [25:0] expq[$];
    logic [25:0] obs[$];

    logic [15:0] m_rate = 16'h0100;
    logic [7:0]  m_min = '0;
    logic        m_en = 1'b0;
    logic        m_vid = 1'b0;

    logic        hold = 1'b0;
    logic [25:0] held;
    logic        lat_arm = 1'b0;
    int          lat_acc = -1;

    y_enhance_apply dut (
        .clk(clk),
        .rst(rst),
        .video_in_data(video_in_data),
        .video_in_valid(video_in_valid),
        .video_in_sop(video_in_sop),
        .video_in_eop(video_in_eop),
        .video_in_ready(video_in_ready),
        .video_out_data(video_out_data),
        .video_out_valid(video_out_valid),
        .video_out_sop(video_out_sop),
        .video_out_eop(video_out_eop),
        .video_out_ready(video_out_ready),
        .rate(rate),
        .min_value(min_value),
        .enable(enable)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        if (rdy_mode == 0) video_out_ready = 1'b0;
        else if (rdy_mode == 1) video_out_ready = 1'b1;
        else video_out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] stretch(input int y, input int mn,
                                           input int rt);
        int dd;
        int p;
        int q;
        dd = (y > mn) ? y - mn : 0;
        p = dd * rt;
`ifdef Y_ENHANCE_ROUND_EN
        q = (p + 128) / 256;
`else
        q = p / 256;
`endif
        if (q > 255) q = 255;
        return 8'(q);
    endfunction

    // Packet-level reference and per-cycle output comparison.
    always @(negedge clk) begin
        logic [23:0] e;
        logic [25:0] got;
        cyc++;
        if (rst) begin
            expq.delete();
            m_rate = 16'h0100;
            m_min = '0;
            m_en = 1'b0;
            m_vid = 1'b0;
            hold = 1'b0;
        end else begin
            got = {video_out_sop, video_out_eop, video_out_data};
            if (hold) begin
                chk("hold_valid", 32'(video_out_valid), 32'd1);
                chk("hold_beat", 32'(got), 32'(held));
            end
            if (video_out_valid && video_out_ready) begin
                if (lat_arm && lat_acc >= 0) begin
                    chk("latency", 32'(cyc - lat_acc), 32'd3);
                    lat_arm = 1'b0;
                end
                if (expq.size() == 0) begin
                    chk("unexpected_beat", 32'(got), 32'h3FFFFFF);
                end else begin
                    chk("out_beat", 32'(got), 32'(expq.pop_front()));
                end
                obs.push_back(got);
            end
            hold = video_out_valid && !video_out_ready;
            held = got;
            if (video_in_valid && video_in_ready) begin
                if (lat_arm && lat_acc < 0) lat_acc = cyc;
                e = video_in_data;
                if (video_in_sop) begin
                    m_rate = rate;
                    m_min = min_value;
                    m_en = enable;
                    m_vid = (video_in_data[3:0] == 4'd0);
                end else if (m_vid && m_en) begin
                    e[23:16] = stretch(int'(video_in_data[23:16]),
                                       int'(m_min), int'(m_rate));
                end
                expq.push_back({video_in_sop, video_in_eop, e});
            end
        end
    end

    task automatic send(input logic [23:0] d, input logic s, input logic e);
        int n;
        bit done;
        n = 0;
        done = 0;
        video_in_valid = 1'b1;
        video_in_data = d;
        video_in_sop = s;
        video_in_eop = e;
        while (!done) begin
            @(negedge clk);
            if (video_in_ready) begin
                done = 1;
            end else if (++n > 2000) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: in_ready stuck at 0");
                done = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        video_in_valid = 1'b0;
        video_in_sop = 1'b0;
        video_in_eop = 1'b0;
    endtask

    task automatic drain();
        int n;
        idle();
        n = 0;
        while ((expq.size() != 0 || video_out_valid) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d beats outstanding", expq.size());
        end
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] px(input logic [7:0] y,
                                       input logic [15:0] c);
        return {y, c};
    endfunction

    logic [23:0] sent[$];
    logic [7:0]  exp_l[4];

    initial begin
        chk("model_80", 32'(stretch(80, 16, 512)), 32'd128);
        chk("model_10", 32'(stretch(10, 16, 512)), 32'd0);
        chk("model_255", 32'(stretch(255, 16, 512)), 32'd255);
`ifdef Y_ENHANCE_ROUND_EN
        chk("model_round", 32'(stretch(17, 16, 384)), 32'd2);
`else
        chk("model_round", 32'(stretch(17, 16, 384)), 32'd1);
`endif

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(video_out_valid), 32'd0);
        chk("rst_data", 32'(video_out_data), 32'd0);
        chk("rst_sop_eop", 32'({video_out_sop, video_out_eop}), 32'd0);
        chk("rst_in_ready", 32'(video_in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // identity, with latency measurement
        obs.delete();
        sent.delete();
        lat_arm = 1'b1;
        lat_acc = -1;
        send(24'h123450, 1'b1, 1'b0);
        sent.push_back(24'h123450);
        for (int i = 0; i < 16; i++) begin
            send(px(8'(i), 16'(i * 1111)), 1'b0, i == 15);
            sent.push_back(px(8'(i), 16'(i * 1111)));
        end
        drain();
        chk("ident_count", 32'(obs.size()), 32'd17);
        for (int i = 0; i < 17 && i < obs.size(); i++)
            chk("ident_data", 32'(obs[i][23:0]), 32'(sent[i]));
        chk("ident_latency_seen", 32'(lat_arm), 32'd0);
        lat_arm = 1'b0;

        // stretch
        obs.delete();
        rate = 16'h0200;
        min_value = 8'd16;
        exp_l = '{8'd128, 8'd0, 8'd255, 8'd0};
        send(24'hA5B6C0, 1'b1, 1'b0);
        send(px(8'd80, 16'h8040), 1'b0, 1'b0);
        send(px(8'd10, 16'h8040), 1'b0, 1'b0);
        send(px(8'd255, 16'h8040), 1'b0, 1'b0);
        send(px(8'd16, 16'h8040), 1'b0, 1'b1);
        drain();
        chk("str_count", 32'(obs.size()), 32'd5);
        if (obs.size() == 5) begin
            chk("str_hdr", 32'(obs[0][23:0]), 32'h00A5B6C0);
            for (int i = 0; i < 4; i++) begin
                chk("str_luma", 32'(obs[i + 1][23:16]), 32'(exp_l[i]));
                chk("str_chroma", 32'(obs[i + 1][15:0]), 32'h8040);
            end
        end

        // coherence across a mid-packet rate change
        obs.delete();
        min_value = 8'd0;
        send(24'h000000, 1'b1, 1'b0);
        send(px(8'd50, 16'h1111), 1'b0, 1'b0);
        rate = 16'h0100;
        send(px(8'd50, 16'h2222), 1'b0, 1'b0);
        send(px(8'd50, 16'h3333), 1'b0, 1'b1);
        send(24'h000000, 1'b1, 1'b0);
        send(px(8'd50, 16'h4444), 1'b0, 1'b1);
        drain();
        chk("coh_count", 32'(obs.size()), 32'd6);
        if (obs.size() == 6) begin
            chk("coh_p1a", 32'(obs[1][23:16]), 32'd100);
            chk("coh_p1c", 32'(obs[3][23:16]), 32'd100);
            chk("coh_p2", 32'(obs[5][23:16]), 32'd50);
        end

        // control packet, then enable=0
        obs.delete();
        rate = 16'h0300;
        send(24'h00000F, 1'b1, 1'b0);
        send(px(8'd100, 16'h5555), 1'b0, 1'b1);
        enable = 1'b0;
        send(24'h000000, 1'b1, 1'b0);
        enable = 1'b1;
        send(px(8'd100, 16'h6666), 1'b0, 1'b1);
        drain();
        chk("ctl_count", 32'(obs.size()), 32'd4);
        if (obs.size() == 4) begin
            chk("ctl_payload", 32'(obs[1][23:0]), 32'h00645555);
            chk("dis_payload", 32'(obs[3][23:0]), 32'h00646666);
        end

        // rounding
        obs.delete();
        rate = 16'h0180;
        min_value = 8'd16;
        send(24'h000000, 1'b1, 1'b1);
        send(24'h000000, 1'b1, 1'b0);
        send(px(8'd17, 16'h0000), 1'b0, 1'b1);
        drain();
        if (obs.size() == 3)
`ifdef Y_ENHANCE_ROUND_EN
            chk("round_17", 32'(obs[2][23:16]), 32'd2);
`else
            chk("round_17", 32'(obs[2][23:16]), 32'd1);
`endif
        else
            chk("round_count", 32'(obs.size()), 32'd3);

        // backpressure on a 20-beat packet
        obs.delete();
        rate = 16'h0100;
        min_value = 8'd0;
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        send(24'h000000, 1'b1, 1'b0);
        send(px(8'd1, 16'h0001), 1'b0, 1'b0);
        send(px(8'd2, 16'h0002), 1'b0, 1'b0);
        idle();
        @(negedge clk);
        chk("bp_in_ready", 32'(video_in_ready), 32'd0);
        chk("bp_out_valid", 32'(video_out_valid), 32'd1);
        repeat (9) @(posedge clk);
        #1;
        rdy_mode = 1;
        for (int i = 3; i < 20; i++)
            send(px(8'(i), 16'(i)), 1'b0, i == 19);
        drain();
        chk("bp_count", 32'(obs.size()), 32'd20);
        if (obs.size() == 20) begin
            chk("bp_sop", 32'(obs[0][25]), 32'd1);
            chk("bp_eop", 32'(obs[19][24]), 32'd1);
            chk("bp_last", 32'(obs[19][23:16]), 32'd19);
        end

        // reset mid-packet
        rate = 16'h0200;
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        send(24'h000000, 1'b1, 1'b0);
        send(px(8'd10, 16'h0A0A), 1'b0, 1'b0);
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rdy_mode = 1;
        @(negedge clk);
        chk("rst_mid_valid", 32'(video_out_valid), 32'd0);
        @(posedge clk);
        #1;
        obs.delete();
        send(px(8'd10, 16'h0B0B), 1'b0, 1'b1);
        drain();
        chk("rst_mid_count", 32'(obs.size()), 32'd1);
        if (obs.size() == 1)
            chk("rst_mid_pass", 32'(obs[0][23:0]), 32'h000A0B0B);

        // randomized traffic
        rdy_mode = 2;
        for (int p = 0; p < 40; p++) begin
            int len;
            int sel;
            len = $urandom_range(0, 12);
            sel = $urandom_range(0, 3);
            rate = (sel == 0) ? 16'h0000 : (sel == 1) ? 16'h0100 :
                   (sel == 2) ? 16'hFFFF : 16'($urandom_range(0, 16'h0400));
            min_value = 8'($urandom_range(0, 80));
            enable = ($urandom_range(0, 5) != 0);
            send({20'($urandom), ($urandom_range(0, 4) == 0) ?
                  4'($urandom_range(1, 15)) : 4'd0},
                 1'b1, len == 0);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    idle();
                    @(posedge clk);
                    #1;
                end
                if ($urandom_range(0, 5) == 0) rate = 16'($urandom);
                if ($urandom_range(0, 5) == 0) min_value = 8'($urandom);
                send(24'($urandom), 1'b0,
                     (i == len - 1) && ($urandom_range(0, 7) != 0));
            end
        end
        drain();
        rdy_mode = 1;
        enable = 1'b1;
        chk("final_queue_empty", 32'(expq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
